// File: rtl/inst_fetch_unit_if.sv
// Signal bundle linking the fetch unit to instruction memory and to the core.
// master = fetch unit side, slave = memory/core side.
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_fault,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: credit-limited memory requests, prefetch FIFO, redirect with stale drain.
// Optional macro IFU_MISALIGN_TRAP_EN: misaligned redirect targets trap into a FAULT state.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  inst_fetch_unit_if.master bus
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_DRAIN = 2'b01
`ifdef IFU_MISALIGN_TRAP_EN
    , ST_FAULT = 2'b10
`endif
  } state_e;

  state_e          state_r;
  logic [31:0]     fetch_pc_r;
  logic [31:0]     resp_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   stale_r;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [31:0]     pc_mem_r   [FIFO_DEPTH];
  logic [31:0]     inst_mem_r [FIFO_DEPTH];
`ifdef IFU_MISALIGN_TRAP_EN
  logic            fault_pend_r;
  logic            misalign_s;
`endif

  logic            req_s;
  logic            grant_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   stale_next_s;
  logic [31:0]     target_s;

  // Request credit, handshake qualifiers and redirect bookkeeping.
  always_comb begin
    req_s        = 1'b0;
    grant_s      = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    stale_next_s = {CW{1'b0}};
    target_s     = 32'h0000_0000;
    if (state_r == ST_FETCH) begin
      req_s = (({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_W);
    end else begin
      req_s = 1'b0;
    end
    grant_s = req_s & bus.imem_gnt;
    push_s  = (state_r == ST_FETCH) & bus.imem_rvalid & ~bus.redirect;
    pop_s   = (count_r != {CW{1'b0}}) & bus.inst_ready & ~bus.redirect;
    // Everything still in flight after a redirect becomes stale, including a same-cycle grant.
    stale_next_s = outstanding_r + stale_r + CW'(grant_s) - CW'(bus.imem_rvalid);
`ifdef IFU_MISALIGN_TRAP_EN
    target_s = bus.redirect_pc;
`else
    target_s = {bus.redirect_pc[31:2], 2'b00};
`endif
  end

`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign_s = |bus.redirect_pc[1:0];
`endif

  // Fetch control: state machine, PC tracking, credit counters and FIFO pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_FETCH;
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      stale_r       <= {CW{1'b0}};
      count_r       <= {CW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
`ifdef IFU_MISALIGN_TRAP_EN
      fault_pend_r  <= 1'b0;
`endif
    end else if (bus.redirect) begin
      fetch_pc_r    <= target_s;
      resp_pc_r     <= target_s;
      outstanding_r <= {CW{1'b0}};
      stale_r       <= stale_next_s;
      count_r       <= {CW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
`ifdef IFU_MISALIGN_TRAP_EN
      fault_pend_r  <= misalign_s;
`endif
      if (stale_next_s != {CW{1'b0}}) begin
        state_r <= ST_DRAIN;
`ifdef IFU_MISALIGN_TRAP_EN
      end else if (misalign_s) begin
        state_r <= ST_FAULT;
`endif
      end else begin
        state_r <= ST_FETCH;
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (grant_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
          end
          if (push_s) begin
            resp_pc_r <= resp_pc_r + 32'd4;
          end
          outstanding_r <= outstanding_r + CW'(grant_s) - CW'(bus.imem_rvalid);
        end
        ST_DRAIN: begin
          if (bus.imem_rvalid) begin
            stale_r <= stale_r - CW'(1);
            if (stale_r == CW'(1)) begin
`ifdef IFU_MISALIGN_TRAP_EN
              state_r <= fault_pend_r ? ST_FAULT : ST_FETCH;
`else
              state_r <= ST_FETCH;
`endif
            end
          end
        end
`ifdef IFU_MISALIGN_TRAP_EN
        ST_FAULT: begin
          state_r <= ST_FAULT;
        end
`endif
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Prefetch storage of {pc, instruction} pairs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_r[i]   <= 32'h0000_0000;
        inst_mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= resp_pc_r;
      inst_mem_r[wr_ptr_r] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req   = req_s;
  assign bus.imem_addr  = fetch_pc_r;
  assign bus.inst       = inst_mem_r[rd_ptr_r];
  assign bus.inst_pc    = pc_mem_r[rd_ptr_r];
  assign bus.inst_valid = (count_r != {CW{1'b0}});
`ifdef IFU_MISALIGN_TRAP_EN
  assign bus.fetch_fault = (state_r == ST_FAULT);
`else
  assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with an in-order instruction memory model of configurable latency.
module tb_inst_fetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          grants   = 0;
  logic        gnt_en   = 1'b0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic        seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: memory drives response/grant, handshake captured, edge, outputs settle.
  task automatic step();
    logic        hs;
    logic [31:0] hs_addr;
    if (reset) begin
      q_addr.delete();
      q_due.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0000_0000;
    end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0000_0000;
    end
    bus.imem_gnt = gnt_en;
    #1;
    hs      = bus.imem_req & bus.imem_gnt;
    hs_addr = bus.imem_addr;
    @(posedge clock);
    #1;
    cyc++;
    if (hs && !reset) begin
      grants++;
      q_addr.push_back(hs_addr);
      q_due.push_back(cyc + lat - 1);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.redirect = 1'b0;
    gnt_en       = 1'b0;
    step();
    step();
    reset  = 1'b0;
    grants = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0000_0000;
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0000_0000;

    // Streaming at one instruction per cycle from reset.
    lat = 1;
    do_reset();
    check("rst_req",   32'(bus.imem_req),    32'd1);
    check("rst_addr",  bus.imem_addr,        32'h0000_0000);
    check("rst_valid", 32'(bus.inst_valid),  32'd0);
    check("rst_inst",  bus.inst,             32'h0000_0000);
    check("rst_pc",    bus.inst_pc,          32'h0000_0000);
    check("rst_fault", 32'(bus.fetch_fault), 32'd0);
    gnt_en = 1'b1;
    bus.inst_ready = 1'b1;
    step();
    check("t1_first_valid", 32'(bus.inst_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_valid", 32'(bus.inst_valid), 32'd1);
      check("t1_pc",    bus.inst_pc,         32'(4 * k));
      check("t1_inst",  bus.inst,            mem_word(32'(4 * k)));
    end

    // Stalled core: credits cap requests at the FIFO depth.
    bus.inst_ready = 1'b0;
    do_reset();
    gnt_en = 1'b1;
    repeat (10) step();
    check("t2_grants", 32'(grants),          32'd4);
    check("t2_req",    32'(bus.imem_req),    32'd0);
    check("t2_addr",   bus.imem_addr,        32'h0000_0010);
    check("t2_valid",  32'(bus.inst_valid),  32'd1);
    check("t2_pc",     bus.inst_pc,          32'h0000_0000);
    check("t2_inst",   bus.inst,             mem_word(32'h0000_0000));
    bus.inst_ready = 1'b1;
    step();
    check("t2_pop_pc", bus.inst_pc,          32'h0000_0004);

    // Redirect with two requests outstanding on a 3-cycle memory.
    lat = 3;
    do_reset();
    gnt_en = 1'b1;
    step();
    step();
    gnt_en = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    step();
    bus.redirect = 1'b0;
    check("t3_drain_req0", 32'(bus.imem_req),   32'd0);
    gnt_en = 1'b1;
    step();
    check("t3_drain_req1", 32'(bus.imem_req),   32'd0);
    check("t3_drain_vld",  32'(bus.inst_valid), 32'd0);
    step();
    check("t3_resume_req",  32'(bus.imem_req),  32'd1);
    check("t3_resume_addr", bus.imem_addr,      32'h0000_0100);
    check("t3_no_spurious", 32'(bus.inst_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      seen = bus.inst_valid;
    end
    check("t3_valid_seen", 32'(seen),   32'd1);
    check("t3_first_pc",   bus.inst_pc, 32'h0000_0100);
    check("t3_first_inst", bus.inst,    mem_word(32'h0000_0100));

    // Redirect coinciding with a response and a grant.
    lat = 1;
    do_reset();
    gnt_en = 1'b1;
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    step();
    bus.redirect = 1'b0;
    check("t4_valid0", 32'(bus.inst_valid), 32'd0);
    check("t4_req0",   32'(bus.imem_req),   32'd0);
    step();
    check("t4_req1",   32'(bus.imem_req),   32'd1);
    check("t4_addr1",  bus.imem_addr,       32'h0000_0040);
    check("t4_valid1", 32'(bus.inst_valid), 32'd0);
    step();
    check("t4_valid2", 32'(bus.inst_valid), 32'd0);
    step();
    check("t4_valid3", 32'(bus.inst_valid), 32'd1);
    check("t4_pc3",    bus.inst_pc,         32'h0000_0040);

    // Address wrap at the top of memory.
    do_reset();
    gnt_en = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    check("t5_req",     32'(bus.imem_req), 32'd1);
    check("t5_addr",    bus.imem_addr,     32'hFFFF_FFFC);
    gnt_en = 1'b1;
    step();
    check("t5_wrap",    bus.imem_addr,     32'h0000_0000);
    step();
    check("t5_pc_top",  bus.inst_pc,       32'hFFFF_FFFC);
    step();
    check("t5_pc_zero", bus.inst_pc,       32'h0000_0000);
    check("t5_inst",    bus.inst,          mem_word(32'h0000_0000));

    // Misaligned redirect target.
    do_reset();
    gnt_en = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    step();
    bus.redirect = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    check("t6_fault",   32'(bus.fetch_fault), 32'd1);
    check("t6_req",     32'(bus.imem_req),    32'd0);
    gnt_en = 1'b1;
    step();
    step();
    check("t6_fault_hold", 32'(bus.fetch_fault), 32'd1);
    check("t6_valid",      32'(bus.inst_valid),  32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect = 1'b0;
    check("t6_fault_clr", 32'(bus.fetch_fault), 32'd0);
    check("t6_req_res",   32'(bus.imem_req),    32'd1);
    check("t6_addr_res",  bus.imem_addr,        32'h0000_0200);
    step();
    step();
    check("t6_pc_res",    bus.inst_pc,          32'h0000_0200);
    check("t6_valid_res", 32'(bus.inst_valid),  32'd1);
`else
    check("t6_fault", 32'(bus.fetch_fault), 32'd0);
    check("t6_req",   32'(bus.imem_req),    32'd1);
    check("t6_addr",  bus.imem_addr,        32'h0000_0100);
    gnt_en = 1'b1;
    step();
    step();
    check("t6_valid", 32'(bus.inst_valid),  32'd1);
    check("t6_pc",    bus.inst_pc,          32'h0000_0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
